// File: rtl/fft_seq_ctrl_if.sv
// Signal bundle between the 16-point FFT sequencing controller and its datapath.
// The controller side uses the master modport; the datapath/top side uses slave.
interface fft_seq_ctrl_if #(
  parameter int MAG_W = 32
);
  logic             data_valid;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic             bf_start;
  logic [3:0]       bf_addr_a;
  logic [3:0]       bf_addr_b;
  logic [2:0]       tw_idx;
  logic [1:0]       stage;
  logic             rd_en;
  logic [3:0]       rd_addr;
  logic [MAG_W-1:0] mag;
  logic             fft_valid;
  logic             done;
  logic [3:0]       freq;
  logic             busy;
  logic             ovf;

  modport master (
    input  data_valid, mag,
    output wr_en, wr_addr, bf_start, bf_addr_a, bf_addr_b, tw_idx, stage,
           rd_en, rd_addr, fft_valid, done, freq, busy, ovf
  );

  modport slave (
    output data_valid, mag,
    input  wr_en, wr_addr, bf_start, bf_addr_a, bf_addr_b, tw_idx, stage,
           rd_en, rd_addr, fft_valid, done, freq, busy, ovf
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 16-point radix-2 FFT: bit-reversed capture, 32 butterflies on one
// shared unit with drain bubbles between stages, then result unload with peak search.
module fft_seq_ctrl #(
  parameter int BF_LAT = 2,
  parameter int MAG_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  fft_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {CAP, BFLY, DRAIN, UNLOAD, FIN} state_t;

  localparam logic [2:0] LAST_DRAIN = 3'(BF_LAT - 1);

  state_t           state_r, state_s;
  logic [3:0]       cnt_r;
  logic [2:0]       k_r;
  logic [1:0]       stage_r;
  logic [2:0]       drain_r;
  logic [4:0]       unl_r;
  logic [3:0]       freq_r;
  logic             ovf_r;
  logic             rd_vld_r;
  logic [3:0]       rd_idx_r;
  logic [MAG_W-1:0] peak_r;
  logic [3:0]       peak_idx_r;

  logic [3:0]       k_ext_s, span_s, pos_s, grp_s, addr_a_s;
  logic [2:0]       tw_s;
  logic             unload_rd_s;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= CAP;
    else     state_r <= state_s;
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      CAP:    if (bus.data_valid && cnt_r == 4'd15) state_s = BFLY; else state_s = CAP;
      BFLY:   if (k_r == 3'd7) state_s = DRAIN; else state_s = BFLY;
      DRAIN: begin
        if (drain_r == LAST_DRAIN) begin
          if (stage_r == 2'd3) state_s = UNLOAD;
          else                 state_s = BFLY;
        end else begin
          state_s = DRAIN;
        end
      end
      UNLOAD: if (unl_r == 5'd16) state_s = FIN; else state_s = UNLOAD;
      FIN:    state_s = CAP;
      default: state_s = CAP;
    endcase
  end

  // Butterfly operand addressing for the current stage and butterfly index
  always_comb begin
    k_ext_s  = {1'b0, k_r};
    span_s   = 4'd1 << stage_r;
    pos_s    = k_ext_s & (span_s - 4'd1);
    grp_s    = k_ext_s >> stage_r;
    addr_a_s = (grp_s << ({1'b0, stage_r} + 3'd1)) | pos_s;
    tw_s     = pos_s[2:0] << (2'd3 - stage_r);
  end

  assign unload_rd_s = (state_r == UNLOAD) && !unl_r[4];

  // Output decode; everything not owned by the current state stays at zero
  always_comb begin
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 4'd0;
    bus.bf_start  = 1'b0;
    bus.bf_addr_a = 4'd0;
    bus.bf_addr_b = 4'd0;
    bus.tw_idx    = 3'd0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = 4'd0;
    bus.fft_valid = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = 1'b1;
    case (state_r)
      CAP: begin
        bus.busy    = 1'b0;
        bus.wr_en   = bus.data_valid;
        bus.wr_addr = bitrev4(cnt_r);
      end
      BFLY: begin
        bus.bf_start  = 1'b1;
        bus.bf_addr_a = addr_a_s;
        bus.bf_addr_b = addr_a_s + span_s;
        bus.tw_idx    = tw_s;
      end
      DRAIN:  bus.busy = 1'b1;
      UNLOAD: begin
        bus.rd_en   = unload_rd_s;
        bus.rd_addr = unload_rd_s ? unl_r[3:0] : 4'd0;
      end
      FIN: begin
        bus.fft_valid = 1'b1;
        bus.done      = 1'b1;
      end
      default: bus.busy = 1'b1;
    endcase
    bus.stage = stage_r;
    bus.freq  = freq_r;
    bus.ovf   = ovf_r;
  end

  // Sequencing counters and the published peak bin
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 4'd0;
      k_r     <= 3'd0;
      stage_r <= 2'd0;
      drain_r <= 3'd0;
      unl_r   <= 5'd0;
      freq_r  <= 4'd0;
    end else begin
      case (state_r)
        CAP:  if (bus.data_valid) cnt_r <= cnt_r + 4'd1;
        BFLY: begin
          k_r     <= k_r + 3'd1;
          drain_r <= 3'd0;
        end
        DRAIN: begin
          drain_r <= drain_r + 3'd1;
          unl_r   <= 5'd0;
          if (drain_r == LAST_DRAIN && stage_r != 2'd3) stage_r <= stage_r + 2'd1;
        end
        UNLOAD: if (!unl_r[4]) unl_r <= unl_r + 5'd1;
        FIN: begin
          cnt_r   <= 4'd0;
          stage_r <= 2'd0;
          k_r     <= 3'd0;
          freq_r  <= peak_idx_r;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky overrun: any sample offered while the frame is being processed is lost
  always_ff @(posedge clk) begin
    if (rst)                             ovf_r <= 1'b0;
    else if (bus.busy && bus.data_valid) ovf_r <= 1'b1;
  end

  // Peak search; strict compare keeps the lowest bin on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_r   <= 1'b0;
      rd_idx_r   <= 4'd0;
      peak_r     <= '0;
      peak_idx_r <= 4'd0;
    end else begin
      rd_vld_r <= unload_rd_s;
      rd_idx_r <= unl_r[3:0];
      if (rd_vld_r && (rd_idx_r == 4'd0 || bus.mag > peak_r)) begin
        peak_r     <= bus.mag;
        peak_idx_r <= rd_idx_r;
      end
    end
  end
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Randomized self-checking bench for fft_seq_ctrl; two instances (BF_LAT 2 and 5)
// run the same frames and are compared against a schedule model built from the FFT rules.
module tb_fft_seq_ctrl;
  localparam int LA = 2;
  localparam int LB = 5;
  localparam int MW = 32;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   exp_freq_prev = 0;

  fft_seq_ctrl_if #(.MAG_W(MW)) ifa ();
  fft_seq_ctrl_if #(.MAG_W(MW)) ifb ();

  fft_seq_ctrl #(.BF_LAT(LA), .MAG_W(MW)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fft_seq_ctrl #(.BF_LAT(LB), .MAG_W(MW)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int cyc;
    int st;
    int a;
    int b;
    int tw;
  } bf_ev_t;

  bf_ev_t      bf_q[$];
  int          wr_cyc_q[$], wr_addr_q[$], rd_cyc_q[$], rd_addr_q[$];
  int          done_q[$], fv_q[$], done_b_q[$], acc_q[$];
  int          bf_b_cnt = 0;
  logic [31:0] tbl[16];
  bit          pa_v = 1'b0, pb_v = 1'b0;
  logic [3:0]  pa_a = 4'd0, pb_a = 4'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor
  initial begin
    bf_ev_t ev;
    forever begin
      @(negedge clk);
      if (ifa.wr_en === 1'b1) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(int'(ifa.wr_addr));
      end
      if (ifa.bf_start === 1'b1) begin
        ev.cyc = cyc; ev.st = int'(ifa.stage); ev.a = int'(ifa.bf_addr_a);
        ev.b = int'(ifa.bf_addr_b); ev.tw = int'(ifa.tw_idx);
        bf_q.push_back(ev);
      end
      if (ifa.rd_en === 1'b1) begin
        rd_cyc_q.push_back(cyc);
        rd_addr_q.push_back(int'(ifa.rd_addr));
      end
      if (ifa.done === 1'b1) done_q.push_back(cyc);
      if (ifa.fft_valid === 1'b1) fv_q.push_back(cyc);
      if (ifb.done === 1'b1) done_b_q.push_back(cyc);
      if (ifb.bf_start === 1'b1) bf_b_cnt++;
    end
  end

  // Datapath stand-in: magnitude of the word read in the previous cycle
  initial begin
    ifa.mag = '0;
    ifb.mag = '0;
    forever begin
      @(negedge clk);
      pa_v = (ifa.rd_en === 1'b1); pa_a = ifa.rd_addr;
      pb_v = (ifb.rd_en === 1'b1); pb_a = ifb.rd_addr;
      @(posedge clk);
      #1;
      ifa.mag = pa_v ? tbl[pa_a] : 32'd0;
      ifb.mag = pb_v ? tbl[pb_a] : 32'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < 4; b++) r = r + (((v >> b) & 1) << (3 - b));
    return r;
  endfunction

  function automatic int peak_bin();
    logic [31:0] mx = tbl[0];
    int idx = 0;
    for (int i = 1; i < 16; i++) if (tbl[i] > mx) mx = tbl[i];
    for (int i = 15; i >= 0; i--) if (tbl[i] == mx) idx = i;
    return idx;
  endfunction

  task automatic clear_events();
    bf_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); rd_cyc_q.delete();
    rd_addr_q.delete(); done_q.delete(); fv_q.delete(); done_b_q.delete(); acc_q.delete();
    bf_b_cnt = 0;
  endtask

  task automatic run_frame(input int gap_max, input bit inject);
    int t, fin_a, fin_b, g, span, pos, a, s, k, n, pk;
    clear_events();
    for (int i = 0; i < 16; i++) begin
      g = int'($urandom_range(gap_max));
      repeat (g) begin
        ifa.data_valid = 1'b0; ifb.data_valid = 1'b0;
        tick();
      end
      ifa.data_valid = 1'b1; ifb.data_valid = 1'b1;
      acc_q.push_back(cyc);
      @(negedge clk);
      chk("cap_busy", 32'(ifa.busy), 0);
      chk("freq_hold", 32'(ifa.freq), exp_freq_prev);
      tick();
    end
    ifa.data_valid = 1'b0; ifb.data_valid = 1'b0;
    t = acc_q[15];
    fin_a = t + 4 * (8 + LA) + 18;
    fin_b = t + 4 * (8 + LB) + 18;
    while (cyc < fin_b + 3) begin
      @(negedge clk);
      if (cyc == t + 1) chk("busy_rise", 32'(ifa.busy), 1);
      if (cyc == fin_a + 1) chk("busy_fall", 32'(ifa.busy), 0);
      if (inject) begin
        if (cyc == t + 2) ifa.data_valid = 1'b1;
        if (cyc == t + 3) begin
          chk("ovf_no_wren", 32'(ifa.wr_en), 0);
          ifa.data_valid = 1'b0;
        end
        if (cyc == t + 4) chk("ovf_set", 32'(ifa.ovf), 1);
        if (cyc == fin_a) chk("ovf_at_fin", 32'(ifa.ovf), 1);
      end
    end
    tick();

    chk("wr_count", wr_cyc_q.size(), 16);
    n = (wr_cyc_q.size() < 16) ? wr_cyc_q.size() : 16;
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", wr_addr_q[i], bitrev(i));
      chk("wr_cyc", wr_cyc_q[i], acc_q[i]);
    end

    chk("bf_count", bf_q.size(), 32);
    n = (bf_q.size() < 32) ? bf_q.size() : 32;
    for (int j = 0; j < n; j++) begin
      s = j / 8; k = j % 8;
      span = 1;
      repeat (s) span = span * 2;
      pos = k % span;
      a = (k / span) * 2 * span + pos;
      chk("bf_cyc", bf_q[j].cyc, t + 1 + s * (8 + LA) + k);
      chk("bf_stage", bf_q[j].st, s);
      chk("bf_a", bf_q[j].a, a);
      chk("bf_b", bf_q[j].b, a + span);
      chk("bf_tw", bf_q[j].tw, pos * (8 / span));
    end
    chk("bf_b_count", bf_b_cnt, 32);

    chk("rd_count", rd_cyc_q.size(), 16);
    n = (rd_cyc_q.size() < 16) ? rd_cyc_q.size() : 16;
    for (int i = 0; i < n; i++) begin
      chk("rd_addr", rd_addr_q[i], i);
      chk("rd_cyc", rd_cyc_q[i], t + 4 * (8 + LA) + 1 + i);
    end

    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cyc", done_q[0], fin_a);
    chk("fv_count", fv_q.size(), 1);
    if (fv_q.size() > 0) chk("fv_cyc", fv_q[0], fin_a);
    chk("done5_count", done_b_q.size(), 1);
    if (done_b_q.size() > 0) chk("done5_cyc", done_b_q[0], fin_b);

    pk = peak_bin();
    chk("freq", 32'(ifa.freq), pk);
    chk("freq5", 32'(ifb.freq), pk);
    exp_freq_prev = pk;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    ifa.data_valid = 1'b0;
    ifb.data_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(ifa.wr_en), 0);
    chk("rst_wr_addr", 32'(ifa.wr_addr), 0);
    chk("rst_bf_start", 32'(ifa.bf_start), 0);
    chk("rst_bf_a", 32'(ifa.bf_addr_a), 0);
    chk("rst_bf_b", 32'(ifa.bf_addr_b), 0);
    chk("rst_tw", 32'(ifa.tw_idx), 0);
    chk("rst_stage", 32'(ifa.stage), 0);
    chk("rst_rd_en", 32'(ifa.rd_en), 0);
    chk("rst_rd_addr", 32'(ifa.rd_addr), 0);
    chk("rst_fft_valid", 32'(ifa.fft_valid), 0);
    chk("rst_done", 32'(ifa.done), 0);
    chk("rst_freq", 32'(ifa.freq), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_ovf", 32'(ifa.ovf), 0);
    tick();

    // Peak with ties, back-to-back capture
    for (int i = 0; i < 16; i++) tbl[i] = 32'd0;
    tbl[3] = 32'd100; tbl[9] = 32'd100; tbl[12] = 32'd50;
    run_frame(0, 1'b0);
    chk("freq_tie", 32'(ifa.freq), 3);
    if (bf_q.size() == 32) begin
      chk("s0k3_a", bf_q[3].a, 6);   chk("s0k3_b", bf_q[3].b, 7);   chk("s0k3_tw", bf_q[3].tw, 0);
      chk("s1k1_a", bf_q[9].a, 1);   chk("s1k1_b", bf_q[9].b, 3);   chk("s1k1_tw", bf_q[9].tw, 4);
      chk("s2k5_a", bf_q[21].a, 9);  chk("s2k5_b", bf_q[21].b, 13); chk("s2k5_tw", bf_q[21].tw, 2);
      chk("s3k5_a", bf_q[29].a, 5);  chk("s3k5_b", bf_q[29].b, 13); chk("s3k5_tw", bf_q[29].tw, 5);
    end

    // Full-range random magnitudes with gapped capture
    for (int i = 0; i < 16; i++) tbl[i] = $urandom();
    run_frame(3, 1'b0);

    // Narrow range so ties are frequent
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) tbl[i] = 32'($urandom_range(7));
      run_frame(2, 1'b0);
    end

    // Overrun during BFLY, with a peak guaranteed away from bin 0
    for (int i = 0; i < 16; i++) tbl[i] = 32'($urandom_range(1000));
    tbl[$urandom_range(15, 1)] = 32'hFFFF_FFFF;
    run_frame(1, 1'b1);
    chk("ovf_sticky", 32'(ifa.ovf), 1);

    // Reset in the middle of UNLOAD
    clear_events();
    for (int i = 0; i < 16; i++) begin
      ifa.data_valid = 1'b1; ifb.data_valid = 1'b1;
      acc_q.push_back(cyc);
      tick();
    end
    ifa.data_valid = 1'b0; ifb.data_valid = 1'b0;
    t = acc_q[15];
    while (cyc < t + 4 * (8 + LA) + 5) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_rd_en", 32'(ifa.rd_en), 1);
    chk("pre_rst_ovf", 32'(ifa.ovf), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(ifa.busy), 0);
    chk("post_rst_ovf", 32'(ifa.ovf), 0);
    chk("post_rst_freq", 32'(ifa.freq), 0);
    chk("post_rst_rd_en", 32'(ifa.rd_en), 0);
    chk("post_rst_stage", 32'(ifa.stage), 0);
    repeat (40) tick();
    chk("no_done", done_q.size(), 0);
    chk("no_done5", done_b_q.size(), 0);
    exp_freq_prev = 0;

    // Recovery frame
    for (int i = 0; i < 16; i++) tbl[i] = 32'($urandom_range(50));
    run_frame(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
